counter_ctrl: RTL

- Controller that sequences the 5-bit LED counter datapath on the iCE40 board.
- A 2^N-clock prescaler generates count ticks.
- The LED value steps up or down on each tick, under commands from a valid/ready command port.
- Sits between board-level command sources (buttons, UART decoder) and the `leds` pins; replaces the free-running counter when software or user control is needed.

---
 rtl/counter_ctrl_pkg.sv | 23 ++
 rtl/counter_ctrl_if.sv | 18 +
 rtl/tick_gen.sv | 28 ++
 rtl/counter_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg -- shared types for the LED counter controller.
//   op_e    : command opcodes carried on the command port
//   state_e : controller FSM states
//   W_DEFAULT : LED/count width used on the board
package counter_ctrl_pkg;

    localparam int W_DEFAULT = 5;

    typedef enum logic [1:0] {
        OP_STOP     = 2'd0,
        OP_RUN_UP   = 2'd1,
        OP_RUN_DOWN = 2'd2,
        OP_LOAD     = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_UP = 2'd1,
        RUN_DN = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if -- valid/ready command port of the LED counter controller.
//   cmd_valid : command present (master -> slave)
//   cmd_ready : slave can take a command this cycle (slave -> master)
//   cmd_op    : opcode (op_e)
//   cmd_arg   : LOAD value, W bits; ignored for other opcodes
interface counter_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int W = W_DEFAULT
);
    logic         cmd_valid;
    logic         cmd_ready;
    op_e          cmd_op;
    logic [W-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_arg, output cmd_ready);
endinterface

// File: rtl/tick_gen.sv
// tick_gen -- N-bit prescaler producing a strobe every 2^N enabled cycles.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable; while low the counter is held at 0
//   clr      : synchronous clear, overrides en
//   tc       : terminal-count pulse, high while enabled and counter == 2^N-1
module tick_gen #(
    parameter int N = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);
    logic [N-1:0] cnt;

    // Counter wraps naturally from all-ones to zero on the terminal cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || !en)
            cnt <= '0;
        else
            cnt <= cnt + N'(1);
    end

    assign tc = en && (cnt == '1);
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl -- command-driven up/down controller for the LED counter.
//   clk, rst : clock, asynchronous active-high reset
//   cmd      : command port (counter_ctrl_if.slave): STOP, RUN_UP, RUN_DOWN, LOAD
//   leds     : current count, registered
//   busy     : high while running up or down, registered with the state
//   tick     : one-cycle pulse in the cycle leds shows a newly applied step
// Parameters: N prescaler width (step every 2^N cycles), WRAP wrap vs.
// saturate-and-stop at the count limits, W count width.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int N    = 6,
    parameter bit WRAP = 1'b1,
    parameter int W    = W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    counter_ctrl_if.slave      cmd,
    output logic [W-1:0]       leds,
    output logic               busy,
    output logic               tick
);
    state_e state;
    logic   ready;
    logic   accept;
    logic   running;
    logic   tc;

    assign accept        = cmd.cmd_valid && ready;
    assign running       = (state == RUN_UP) || (state == RUN_DN);
    assign cmd.cmd_ready = ready;

    // Any accepted command restarts the prescaler, so a command arriving on
    // the terminal-count cycle swallows that step.
    tick_gen #(.N(N)) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (running),
        .clr (accept),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            leds  <= '0;
            busy  <= 1'b0;
            tick  <= 1'b0;
            ready <= 1'b0;
        end else begin
            tick  <= 1'b0;
            ready <= 1'b1;
            if (accept) begin
                case (cmd.cmd_op)
                    OP_STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    OP_RUN_UP: begin
                        state <= RUN_UP;
                        busy  <= 1'b1;
                    end
                    OP_RUN_DOWN: begin
                        state <= RUN_DN;
                        busy  <= 1'b1;
                    end
                    default: begin
                        // LOAD: one settle cycle with ready low; run state kept.
                        leds  <= cmd.cmd_arg;
                        ready <= 1'b0;
                        if (state == DONE)
                            state <= IDLE;
                    end
                endcase
            end else if (tc) begin
                if (state == RUN_UP) begin
                    if (!WRAP && leds == '1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        leds <= leds + W'(1);
                        tick <= 1'b1;
                    end
                end else begin
                    if (!WRAP && leds == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        leds <= leds - W'(1);
                        tick <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
